// File: rtl/regfile_mp.sv
// Multi-port integer register file with write-to-read bypass and a busy scoreboard.
// After reset a clear sequencer walks the storage and zeroes it, so the array needs no reset.
module regfile_mp #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned NREG    = 32,
  parameter int unsigned NREAD   = 2,
  parameter int unsigned NWRITE  = 1,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned ZERO_R0 = 1,
  localparam int unsigned AW     = $clog2(NREG)
) (
  input  logic                   clk,
  input  logic                   rst,
  output logic                   ready,
  input  logic [NREAD*AW-1:0]    rs,
  output logic [NREAD*XLEN-1:0]  rdata,
  output logic [NREAD-1:0]       rs_busy,
  input  logic                   issue_we,
  input  logic [AW-1:0]          issue_rd,
  input  logic [NWRITE-1:0]      wb_we,
  input  logic [NWRITE*AW-1:0]   wb_rd,
  input  logic [NWRITE*XLEN-1:0] wb_data
);

  typedef enum logic {
    StClear,
    StReady
  } state_e;

  state_e             state_q, state_d;
  logic [AW-1:0]      clr_idx_q, clr_idx_d;
  logic               clr_we;
  logic               run;

  logic [XLEN-1:0]    mem_q [NREG];
  logic [NREG-1:0]    busy_q, busy_d;

  logic [NWRITE-1:0]  wr_en;
  logic               issue_en;

  logic [NREAD-1:0]   rd_hit;
  logic [XLEN-1:0]    rd_fwd [NREAD];

  assign run   = (state_q == StReady);
  assign ready = run;

  // Clear sequencer: step through every register once, then park in ready for good.
  always_comb begin
    state_d   = state_q;
    clr_idx_d = clr_idx_q;
    clr_we    = 1'b0;
    case (state_q)
      StClear: begin
        clr_we = 1'b1;
        if (clr_idx_q == AW'(NREG - 1)) begin
          state_d = StReady;
        end else begin
          clr_idx_d = clr_idx_q + AW'(1);
        end
      end
      StReady: begin
        state_d = StReady;
      end
      default: begin
        state_d = StClear;
      end
    endcase
  end

  // Sequencer state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StClear;
      clr_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_idx_q <= clr_idx_d;
    end
  end

  // Qualified writeback/issue enables: ignored while clearing, r0 writes dropped when hardwired.
  always_comb begin
    wr_en = '0;
    for (int p = 0; p < NWRITE; p++) begin
      wr_en[p] = run && wb_we[p] &&
                 !((ZERO_R0 != 0) && (wb_rd[p*AW +: AW] == '0));
    end
    issue_en = run && issue_we && !((ZERO_R0 != 0) && (issue_rd == '0));
  end

  // Storage array, no reset. Later ports are applied last so the highest index wins.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      mem_q[clr_idx_q] <= '0;
    end
    for (int p = 0; p < NWRITE; p++) begin
      if (wr_en[p]) begin
        mem_q[wb_rd[p*AW +: AW]] <= wb_data[p*XLEN +: XLEN];
      end
    end
  end

  // Scoreboard next state: writebacks clear first, then issue sets, so issue wins on a collision.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NWRITE; p++) begin
      if (wr_en[p]) begin
        busy_d[wb_rd[p*AW +: AW]] = 1'b0;
      end
    end
    if (issue_en) begin
      busy_d[issue_rd] = 1'b1;
    end
  end

  // Scoreboard register; reset clears every busy bit immediately.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  // Forwarding match per read port; scanning upward leaves the highest matching port's data.
  always_comb begin
    rd_hit = '0;
    for (int k = 0; k < NREAD; k++) begin
      rd_fwd[k] = '0;
      for (int p = 0; p < NWRITE; p++) begin
        if (wb_we[p] && (wb_rd[p*AW +: AW] == rs[k*AW +: AW])) begin
          rd_hit[k] = 1'b1;
          rd_fwd[k] = wb_data[p*XLEN +: XLEN];
        end
      end
    end
  end

  // Read ports: forced to zero until ready, r0 hardwired, forwarded data beats stored data.
  always_comb begin
    rdata   = '0;
    rs_busy = '0;
    for (int k = 0; k < NREAD; k++) begin
      if (!run) begin
        rdata[k*XLEN +: XLEN] = '0;
        rs_busy[k]            = 1'b0;
      end else if ((ZERO_R0 != 0) && (rs[k*AW +: AW] == '0)) begin
        rdata[k*XLEN +: XLEN] = '0;
        rs_busy[k]            = 1'b0;
      end else if ((BYPASS != 0) && rd_hit[k]) begin
        rdata[k*XLEN +: XLEN] = rd_fwd[k];
        rs_busy[k]            = 1'b0;
      end else begin
        rdata[k*XLEN +: XLEN] = mem_q[rs[k*AW +: AW]];
        rs_busy[k]            = busy_q[rs[k*AW +: AW]];
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: directed scenarios plus randomized traffic
// compared against an array-based reference model.
module tb_regfile_mp;

  localparam int unsigned XLEN   = 32;
  localparam int unsigned NREG   = 32;
  localparam int unsigned NREAD  = 2;
  localparam int unsigned NWRITE = 2;
  localparam int unsigned AW     = 5;

  logic                   clk = 1'b0;
  logic                   rst;
  logic                   ready;
  logic [NREAD*AW-1:0]    rs;
  logic [NREAD*XLEN-1:0]  rdata;
  logic [NREAD-1:0]       rs_busy;
  logic                   issue_we;
  logic [AW-1:0]          issue_rd;
  logic [NWRITE-1:0]      wb_we;
  logic [NWRITE*AW-1:0]   wb_rd;
  logic [NWRITE*XLEN-1:0] wb_data;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state.
  logic [XLEN-1:0] m_reg [NREG];
  bit              m_busy [NREG];
  bit              m_ready;
  int              m_cnt;

  regfile_mp #(
    .XLEN    (XLEN),
    .NREG    (NREG),
    .NREAD   (NREAD),
    .NWRITE  (NWRITE),
    .BYPASS  (1),
    .ZERO_R0 (1)
  ) u_dut (
    .clk      (clk),
    .rst      (rst),
    .ready    (ready),
    .rs       (rs),
    .rdata    (rdata),
    .rs_busy  (rs_busy),
    .issue_we (issue_we),
    .issue_rd (issue_rd),
    .wb_we    (wb_we),
    .wb_rd    (wb_rd),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ready = 1'b0;
    m_cnt   = 0;
    for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
  endtask

  // Expected read value for an address given the inputs currently applied.
  function automatic logic [XLEN-1:0] exp_data(input int a);
    if (!m_ready || a == 0) return '0;
    for (int p = NWRITE - 1; p >= 0; p--) begin
      if (wb_we[p] && int'(wb_rd[p*AW +: AW]) == a) return wb_data[p*XLEN +: XLEN];
    end
    return m_reg[a];
  endfunction

  function automatic bit exp_busy(input int a);
    if (!m_ready || a == 0) return 1'b0;
    for (int p = 0; p < NWRITE; p++) begin
      if (wb_we[p] && int'(wb_rd[p*AW +: AW]) == a) return 1'b0;
    end
    return m_busy[a];
  endfunction

  task automatic compare_all();
    int a;
    check_eq("ready", 32'(ready), 32'(m_ready));
    for (int k = 0; k < NREAD; k++) begin
      a = int'(rs[k*AW +: AW]);
      check_eq($sformatf("rdata%0d r%0d", k, a), rdata[k*XLEN +: XLEN], exp_data(a));
      check_eq($sformatf("rs_busy%0d r%0d", k, a), 32'(rs_busy[k]), 32'(exp_busy(a)));
    end
  endtask

  // Apply one rising edge to the model using the inputs held across it.
  task automatic model_edge();
    int rd;
    if (!rst) begin
      model_reset();
    end else if (!m_ready) begin
      m_cnt++;
      if (m_cnt == NREG) begin
        m_ready = 1'b1;
        for (int i = 0; i < NREG; i++) m_reg[i] = '0;
      end
    end else begin
      for (int p = 0; p < NWRITE; p++) begin
        rd = int'(wb_rd[p*AW +: AW]);
        if (wb_we[p] && rd != 0) begin
          m_reg[rd]  = wb_data[p*XLEN +: XLEN];
          m_busy[rd] = 1'b0;
        end
      end
      if (issue_we && issue_rd != 0) m_busy[int'(issue_rd)] = 1'b1;
    end
  endtask

  // Entered just after a falling edge with inputs set; leaves just after the next falling edge.
  task automatic cycle();
    #1;
    if (!rst) model_reset();
    compare_all();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    rs       = '0;
    issue_we = 1'b0;
    issue_rd = '0;
    wb_we    = '0;
    wb_rd    = '0;
    wb_data  = '0;
  endtask

  task automatic set_rs(input int k, input int a);
    rs[k*AW +: AW] = AW'(a);
  endtask

  task automatic set_wb(input int p, input bit we, input int rd, input logic [XLEN-1:0] d);
    wb_we[p]               = we;
    wb_rd[p*AW +: AW]      = AW'(rd);
    wb_data[p*XLEN +: XLEN] = d;
  endtask

  // Narrow address range half the time so ports collide often.
  function automatic int rnd_addr();
    return ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, NREG - 1));
  endfunction

  task automatic rand_inputs();
    for (int k = 0; k < NREAD; k++) set_rs(k, rnd_addr());
    issue_we = 1'($urandom_range(0, 1));
    issue_rd = AW'(rnd_addr());
    for (int p = 0; p < NWRITE; p++) set_wb(p, 1'($urandom_range(0, 1)), rnd_addr(), $urandom);
  endtask

  task automatic wait_ready();
    int n = 0;
    for (int i = 0; i < 40; i++) begin
      rand_inputs();
      cycle();
      n++;
      if (ready === 1'b1) break;
    end
    check_eq("ready_latency", 32'(n), 32'(NREG));
    idle();
  endtask

  initial begin
    rst = 1'b0;
    idle();
    model_reset();
    @(negedge clk);
    cycle();
    rand_inputs();
    cycle();

    // Release reset: ready exactly NREG cycles later, storage reads zero.
    rst = 1'b1;
    wait_ready();
    for (int a = 1; a < NREG; a += 2) begin
      idle();
      set_rs(0, a);
      set_rs(1, a + 1);
      cycle();
    end

    // Same-cycle bypass.
    idle();
    set_wb(0, 1'b1, 5, 32'hDEADBEEF);
    set_rs(0, 5);
    #1 check_eq("bypass_same", rdata[31:0], 32'hDEADBEEF);
    cycle();
    idle();
    set_rs(0, 5);
    #1 check_eq("bypass_next", rdata[31:0], 32'hDEADBEEF);
    cycle();

    // r0 hardwired and never busy.
    idle();
    set_wb(0, 1'b1, 0, 32'h1234);
    issue_we = 1'b1;
    issue_rd = '0;
    cycle();
    idle();
    set_rs(0, 0);
    #1;
    check_eq("r0_data", rdata[31:0], 32'h0);
    check_eq("r0_busy", 32'(rs_busy[0]), 32'h0);
    cycle();

    // Scoreboard set/clear and issue-beats-writeback collision.
    idle();
    issue_we = 1'b1;
    issue_rd = 5'd7;
    cycle();
    idle();
    set_rs(0, 7);
    #1 check_eq("r7_busy_set", 32'(rs_busy[0]), 32'h1);
    cycle();
    set_rs(0, 7);
    set_wb(0, 1'b1, 7, 32'h55);
    #1;
    check_eq("r7_busy_wb", 32'(rs_busy[0]), 32'h0);
    check_eq("r7_data_wb", rdata[31:0], 32'h55);
    cycle();
    idle();
    set_rs(0, 7);
    #1 check_eq("r7_busy_after", 32'(rs_busy[0]), 32'h0);
    cycle();
    issue_we = 1'b1;
    issue_rd = 5'd7;
    set_wb(0, 1'b1, 7, 32'h66);
    cycle();
    idle();
    set_rs(0, 7);
    #1 check_eq("r7_busy_collide", 32'(rs_busy[0]), 32'h1);
    cycle();

    // Two ports to one register: highest port wins.
    idle();
    set_wb(0, 1'b1, 3, 32'hA);
    set_wb(1, 1'b1, 3, 32'hB);
    set_rs(0, 3);
    #1 check_eq("dual_wr_fwd", rdata[31:0], 32'hB);
    cycle();
    idle();
    set_rs(0, 3);
    set_rs(1, 3);
    #1 check_eq("dual_wr_stored", rdata[63:32], 32'hB);
    cycle();

    // Reset mid-clear after dirtying r1.
    idle();
    set_wb(0, 1'b1, 1, 32'h77);
    issue_we = 1'b1;
    issue_rd = 5'd1;
    cycle();
    idle();
    set_rs(0, 1);
    #1 check_eq("r1_busy_pre", 32'(rs_busy[0]), 32'h1);
    cycle();
    set_rs(0, 1);
    rst = 1'b0;
    #1;
    check_eq("rst_busy", 32'(rs_busy[0]), 32'h0);
    check_eq("rst_ready", 32'(ready), 32'h0);
    cycle();
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      rand_inputs();
      cycle();
    end
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    wait_ready();
    set_rs(0, 1);
    #1;
    check_eq("r1_after_clear", rdata[31:0], 32'h0);
    check_eq("r1_busy_clear", 32'(rs_busy[0]), 32'h0);
    cycle();

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 600; i++) begin
      rand_inputs();
      rst = ($urandom_range(0, 199) == 0) ? 1'b0 : 1'b1;
      cycle();
    end
    rst = 1'b1;
    idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
